inst_fetch_ctrl: RTL and testbench

- Fetch-control stage directly upstream of the instruction buffer.
- Owns the PC and issues one fetch request at a time to the ICache.
- Forwards up to two returned instructions, with their addresses and valid flags, to the buffer's push port.
- Handles buffer back-pressure, line-boundary truncation and pipeline redirects, including discarding an in-flight response.

---
 rtl/inst_fetch_ctrl_pkg.sv | 8 +
 rtl/inst_fetch_ctrl_pc_next.sv | 15 +
 rtl/inst_fetch_ctrl.sv | 77 +++++++
 tb/tb_inst_fetch_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_ctrl_pkg.sv
// inst_fetch_ctrl_pkg: reset PC, line geometry and fetch FSM state encodings.
package inst_fetch_ctrl_pkg;
  localparam logic [31:0] RESET_PC_DEF = 32'hBFC00000;
  localparam int LINE_OFFSET_BITS_DEF = 5;
  localparam logic [1:0] FETCH_REQ = 2'd0;
  localparam logic [1:0] FETCH_WAIT = 2'd1;
  localparam logic [1:0] FETCH_DISCARD = 2'd2;
endpackage

// File: rtl/inst_fetch_ctrl_pc_next.sv
// inst_fetch_ctrl_pc_next: last-word-of-line flag and sequential next pc for a fetch pair.
module inst_fetch_ctrl_pc_next
  import inst_fetch_ctrl_pkg::*;
#(
  parameter int LINE_OFFSET_BITS = LINE_OFFSET_BITS_DEF
) (
  input  logic [31:0] fetch_addr,
  output logic        last_word,
  output logic [31:0] next_pc
);
  always_comb begin
    last_word = &fetch_addr[LINE_OFFSET_BITS-1:2];
    next_pc = fetch_addr + (last_word ? 32'd4 : 32'd8);
  end
endmodule

// File: rtl/inst_fetch_ctrl.sv
// inst_fetch_ctrl: owns the PC, issues one ICache fetch at a time and forwards
// up to two returned words to the instruction buffer, honouring redirects.
module inst_fetch_ctrl
  import inst_fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter int LINE_OFFSET_BITS = LINE_OFFSET_BITS_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        buffer_full_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_inst1_i,
  input  logic [31:0] resp_inst2_i,
  output logic [31:0] inst1_o,
  output logic [31:0] inst2_o,
  output logic [31:0] inst1_addr_o,
  output logic [31:0] inst2_addr_o,
  output logic        inst1_valid_o,
  output logic        inst2_valid_o
);
  logic [1:0] state;
  logic [31:0] pc;
  logic [31:0] fetch_addr;
  logic [31:0] next_pc;
  logic [31:0] target;
  logic last_word;
  logic accept;
  logic take;

  inst_fetch_ctrl_pc_next #(.LINE_OFFSET_BITS(LINE_OFFSET_BITS)) u_pc_next (
    .fetch_addr(fetch_addr),
    .last_word(last_word),
    .next_pc(next_pc)
  );

  always_comb begin
    target = redirect_pc_i & ~32'h3;
    req_valid_o = !rst && state == FETCH_REQ && !buffer_full_i && !redirect_i;
    req_addr_o = pc;
    accept = req_valid_o && req_ready_i;
    take = !rst && state == FETCH_WAIT && resp_valid_i && !redirect_i;
    inst1_valid_o = take;
    inst2_valid_o = take && !last_word;
    inst1_o = take ? resp_inst1_i : 32'd0;
    inst2_o = take ? resp_inst2_i : 32'd0;
    inst1_addr_o = take ? fetch_addr : 32'd0;
    inst2_addr_o = take ? fetch_addr + 32'd4 : 32'd0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FETCH_REQ;
      pc <= RESET_PC;
      fetch_addr <= 32'd0;
    end else begin
      if (redirect_i) pc <= target;
      else if (take) pc <= next_pc;
      if (accept) fetch_addr <= pc;
      case (state)
        FETCH_REQ: state <= accept ? FETCH_WAIT : FETCH_REQ;
        FETCH_WAIT: state <= resp_valid_i ? FETCH_REQ : (redirect_i ? FETCH_DISCARD : FETCH_WAIT);
        FETCH_DISCARD: state <= resp_valid_i ? FETCH_REQ : FETCH_DISCARD;
        default: state <= FETCH_REQ;
      endcase
    end
  end

  // A response with nothing outstanding is an ICache protocol error; it is ignored.
  resp_without_req: assert property (@(posedge clk) disable iff (rst)
    !(resp_valid_i && state == FETCH_REQ));
endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb_inst_fetch_ctrl: directed fetch/redirect/back-pressure sequence with hand-computed expectations.
module tb_inst_fetch_ctrl;
  logic        clk = 0;
  logic        rst = 1;
  logic        redirect_i = 0;
  logic [31:0] redirect_pc_i = 0;
  logic        buffer_full_i = 0;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i = 0;
  logic        resp_valid_i = 0;
  logic [31:0] resp_inst1_i = 0;
  logic [31:0] resp_inst2_i = 0;
  logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
  logic        inst1_valid_o, inst2_valid_o;
  int checks = 0;
  int failures = 0;

  inst_fetch_ctrl dut (
    .clk(clk), .rst(rst), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .buffer_full_i(buffer_full_i), .req_valid_o(req_valid_o), .req_addr_o(req_addr_o),
    .req_ready_i(req_ready_i), .resp_valid_i(resp_valid_i), .resp_inst1_i(resp_inst1_i),
    .resp_inst2_i(resp_inst2_i), .inst1_o(inst1_o), .inst2_o(inst2_o),
    .inst1_addr_o(inst1_addr_o), .inst2_addr_o(inst2_addr_o),
    .inst1_valid_o(inst1_valid_o), .inst2_valid_o(inst2_valid_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step();
    #1;
    chk("rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("rst_v1", 32'(inst1_valid_o), 32'd0);
    chk("rst_v2", 32'(inst2_valid_o), 32'd0);
    rst = 0;
    req_ready_i = 1;
    #1;
    chk("first_req_valid", 32'(req_valid_o), 32'd1);
    chk("first_req_addr", req_addr_o, 32'hBFC00000);
    step();
    req_ready_i = 0;
    resp_valid_i = 1;
    resp_inst1_i = 32'h11111111;
    resp_inst2_i = 32'h22222222;
    #1;
    chk("wait_req_valid", 32'(req_valid_o), 32'd0);
    chk("resp1_v1", 32'(inst1_valid_o), 32'd1);
    chk("resp1_v2", 32'(inst2_valid_o), 32'd1);
    chk("resp1_a1", inst1_addr_o, 32'hBFC00000);
    chk("resp1_a2", inst2_addr_o, 32'hBFC00004);
    chk("resp1_d1", inst1_o, 32'h11111111);
    chk("resp1_d2", inst2_o, 32'h22222222);
    step();
    resp_valid_i = 0;
    req_ready_i = 1;
    #1;
    chk("second_req_valid", 32'(req_valid_o), 32'd1);
    chk("second_req_addr", req_addr_o, 32'hBFC00008);
    // Redirect in REQ to the last word of a line.
    redirect_i = 1;
    redirect_pc_i = 32'hBFC0001C;
    #1;
    chk("redir_req_valid", 32'(req_valid_o), 32'd0);
    step();
    redirect_i = 0;
    #1;
    chk("lastw_req_addr", req_addr_o, 32'hBFC0001C);
    step();
    req_ready_i = 0;
    resp_valid_i = 1;
    resp_inst1_i = 32'hA0A0A0A0;
    #1;
    chk("lastw_v1", 32'(inst1_valid_o), 32'd1);
    chk("lastw_v2", 32'(inst2_valid_o), 32'd0);
    chk("lastw_a1", inst1_addr_o, 32'hBFC0001C);
    step();
    resp_valid_i = 0;
    buffer_full_i = 1;
    req_ready_i = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("full_req_valid", 32'(req_valid_o), 32'd0);
      step();
    end
    buffer_full_i = 0;
    #1;
    chk("after_full_valid", 32'(req_valid_o), 32'd1);
    chk("after_full_addr", req_addr_o, 32'hBFC00020);
    step();
    req_ready_i = 0;
    redirect_i = 1;
    redirect_pc_i = 32'h80001000;
    #1;
    chk("wait_redir_v1", 32'(inst1_valid_o), 32'd0);
    step();
    redirect_i = 0;
    #1;
    chk("discard_req_valid", 32'(req_valid_o), 32'd0);
    step();
    resp_valid_i = 1;
    #1;
    chk("discard_v1", 32'(inst1_valid_o), 32'd0);
    chk("discard_v2", 32'(inst2_valid_o), 32'd0);
    step();
    resp_valid_i = 0;
    req_ready_i = 1;
    #1;
    chk("post_discard_valid", 32'(req_valid_o), 32'd1);
    chk("post_discard_addr", req_addr_o, 32'h80001000);
    step();
    req_ready_i = 0;
    redirect_i = 1;
    redirect_pc_i = 32'h80002000;
    resp_valid_i = 1;
    #1;
    chk("same_cyc_v1", 32'(inst1_valid_o), 32'd0);
    chk("same_cyc_v2", 32'(inst2_valid_o), 32'd0);
    step();
    redirect_i = 0;
    resp_valid_i = 0;
    #1;
    chk("same_cyc_req_valid", 32'(req_valid_o), 32'd1);
    chk("same_cyc_addr", req_addr_o, 32'h80002000);
    redirect_i = 1;
    redirect_pc_i = 32'h80000002;
    step();
    redirect_i = 0;
    #1;
    chk("unaligned_addr", req_addr_o, 32'h80000000);
    // Wrap-around of the sequential pc.
    redirect_i = 1;
    redirect_pc_i = 32'hFFFFFFF8;
    step();
    redirect_i = 0;
    req_ready_i = 1;
    step();
    req_ready_i = 0;
    resp_valid_i = 1;
    #1;
    chk("wrap_a2", inst2_addr_o, 32'hFFFFFFFC);
    chk("wrap_v2", 32'(inst2_valid_o), 32'd1);
    step();
    resp_valid_i = 0;
    req_ready_i = 1;
    #1;
    chk("wrap_next_addr", req_addr_o, 32'h00000000);
    step();
    req_ready_i = 0;
    #1;
    rst = 1;
    #1;
    chk("mid_rst_req_valid", 32'(req_valid_o), 32'd0);
    chk("mid_rst_v1", 32'(inst1_valid_o), 32'd0);
    step();
    rst = 0;
    req_ready_i = 1;
    #1;
    chk("post_rst_valid", 32'(req_valid_o), 32'd1);
    chk("post_rst_addr", req_addr_o, 32'hBFC00000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
